// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned MULT_W    = 8;
    localparam int unsigned PROD_W    = 16;
    localparam logic [3:0]  STEP_LAST = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder; purely combinational.
module rca_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       co
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[8];

endmodule

// File: rtl/seq_mult_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier; one operand pair per start,
// product and done pulse 8 cycles after the accept edge.
module seq_mult_8bit
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MULT_W-1:0]   a,
    input  logic [MULT_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [PROD_W-1:0]   p
);

    state_t              state_q, state_d;
    logic [MULT_W-1:0]   mcand_q, mcand_d;
    logic [MULT_W-1:0]   acc_q, acc_d;
    logic [MULT_W-1:0]   mlr_q, mlr_d;
    logic                carry_q, carry_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PROD_W-1:0]   p_q, p_d;

    logic [MULT_W-1:0]   add_s;
    logic                add_co;

    rca_8bit u_rca (
        .a   (acc_q),
        .b   (mcand_q),
        .cin (1'b0),
        .s   (add_s),
        .co  (add_co)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mlr_d   = mlr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mlr_d   = b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // The 9-bit sum is shifted right once, so the carry bit always lands in acc.
                if (mlr_q[0]) begin
                    {carry_d, acc_d, mlr_d} = {1'b0, add_co, add_s, mlr_q[MULT_W-1:1]};
                end else begin
                    {carry_d, acc_d, mlr_d} = {1'b0, 1'b0, acc_q, mlr_q[MULT_W-1:1]};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == STEP_LAST) begin
                    p_d     = {acc_d, mlr_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mlr_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mlr_q   <= mlr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Carry is architecturally visible state but never feeds the datapath.
    logic unused_carry;
    assign unused_carry = carry_q;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Directed self-checking bench for seq_mult_8bit.
module tb_seq_mult_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_p;
    int          n;
    bit          seen;

    seq_mult_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp, input string tag);
        int  cyc;
        int  busy_n;
        bit  got_done;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        check({tag, "_busy_acc"}, busy, 1);
        check({tag, "_p_hold"}, p, last_p);
        busy_n   = 1;
        cyc      = 0;
        got_done = 0;
        while (!got_done && cyc < 20) begin
            tick();
            cyc++;
            busy_n += int'(busy);
            if (done) got_done = 1;
        end
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_p"}, p, exp);
        tick();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_len"}, busy_n, 9);
        last_p = exp;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        last_p = 16'h0000;
        tick();
        tick();
        check("rst_p", p, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        run_op(8'h00, 8'hA5, 16'h0000, "zero");
        run_op(8'hB5, 8'hF3, 16'hABCF, "b5f3");
        repeat (3) tick();
        check("hold_idle", p, 16'hABCF);
        run_op(8'h8D, 8'hD7, 16'h766B, "8dd7");
        run_op(8'hFF, 8'hFF, 16'hFE01, "ffff");
        run_op(8'h0F, 8'h0F, 16'h00E1, "0f0f");

        // start held high: second accept must land exactly 10 edges after the first
        a     = 8'h03;
        b     = 8'h05;
        start = 1'b1;
        tick();
        check("held_busy_acc", busy, 1);
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (n == 3) begin
                a = 8'hFF;
                b = 8'hFF;
            end
            if (done) seen = 1;
        end
        check("held_latency", n, 8);
        check("held_p", p, 16'h000F);
        tick();
        check("held_no_accept_done", busy, 0);
        tick();
        check("held_reaccept", busy, 1);
        start = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (done) seen = 1;
        end
        check("held2_latency", n, 8);
        check("held2_p", p, 16'hFE01);
        tick();

        // reset during the 4th CALC step aborts without a done pulse
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_p", p, 16'h0000);
        seen = 0;
        repeat (12) begin
            tick();
            if (done || busy) seen = 1;
        end
        check("abort_quiet", seen, 0);
        last_p = 16'h0000;
        run_op(8'h12, 8'h34, 16'h03A8, "1234");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
